// File: rtl/ls_issue_scheduler.sv
// ls_issue_scheduler: in-order load/store issue queue with CDB operand snooping
module ls_issue_scheduler #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        dispatch_valid,
  input  logic [4:0]  dispatch_op,
  input  logic [2:0]  dispatch_rob,
  input  logic [31:0] dispatch_base_val,
  input  logic [2:0]  dispatch_base_tag,
  input  logic        dispatch_base_ready,
  input  logic [31:0] dispatch_imm,
  input  logic [31:0] dispatch_data_val,
  input  logic [2:0]  dispatch_data_tag,
  input  logic        dispatch_data_ready,
  output logic        full,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_rob,
  input  logic [31:0] cdb_value,
  input  logic        au_ready,
  output logic        issue_valid,
  output logic [31:0] value1,
  output logic [31:0] value2,
  output logic [4:0]  op_output,
  output logic [2:0]  rob_number_output,
  output logic [31:0] ls_value
);
  logic [4:0]       r_op   [DEPTH];
  logic [2:0]       r_rob  [DEPTH];
  logic [31:0]      r_bval [DEPTH];
  logic [2:0]       r_btag [DEPTH];
  logic             r_brdy [DEPTH];
  logic [31:0]      r_imm  [DEPTH];
  logic [31:0]      r_dval [DEPTH];
  logic [2:0]       r_dtag [DEPTH];
  logic             r_drdy [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_issue, w_push, w_bhit, w_dhit;
  assign full    = r_count == (PTR_W+1)'(DEPTH);
  assign w_issue = r_count != '0 && r_brdy[r_head] && r_drdy[r_head] && au_ready && !flush;
  assign w_push  = dispatch_valid && !full && !flush;
  // a dispatched operand whose producer broadcasts this very cycle would otherwise miss its wakeup
  assign w_bhit  = cdb_valid && !dispatch_base_ready && dispatch_base_tag == cdb_rob;
  assign w_dhit  = cdb_valid && !dispatch_data_ready && dispatch_data_tag == cdb_rob;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      issue_valid       <= 1'b0;
      value1            <= '0;
      value2            <= '0;
      op_output         <= '0;
      rob_number_output <= '0;
      ls_value          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_brdy[i] <= 1'b0;
        r_drdy[i] <= 1'b0;
      end
    end else if (flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      issue_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_brdy[i] <= 1'b0;
        r_drdy[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && !r_brdy[i] && r_btag[i] == cdb_rob) begin
          r_bval[i] <= cdb_value;
          r_brdy[i] <= 1'b1;
        end
        if (cdb_valid && !r_drdy[i] && r_dtag[i] == cdb_rob) begin
          r_dval[i] <= cdb_value;
          r_drdy[i] <= 1'b1;
        end
      end
      if (w_push) begin
        r_op[r_tail]   <= dispatch_op;
        r_rob[r_tail]  <= dispatch_rob;
        r_bval[r_tail] <= w_bhit ? cdb_value : dispatch_base_val;
        r_btag[r_tail] <= dispatch_base_tag;
        r_brdy[r_tail] <= dispatch_base_ready || w_bhit;
        r_imm[r_tail]  <= dispatch_imm;
        r_dval[r_tail] <= w_dhit ? cdb_value : dispatch_data_val;
        r_dtag[r_tail] <= dispatch_data_tag;
        r_drdy[r_tail] <= dispatch_data_ready || w_dhit;
        r_tail         <= r_tail + PTR_W'(1);
      end
      if (w_issue) begin
        value1            <= r_bval[r_head];
        value2            <= r_imm[r_head];
        op_output         <= r_op[r_head];
        rob_number_output <= r_rob[r_head];
        ls_value          <= r_dval[r_head];
        r_head            <= r_head + PTR_W'(1);
      end
      issue_valid <= w_issue;
      r_count     <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_issue);
    end
  end
endmodule

// File: tb/tb_ls_issue_scheduler.sv
// tb_ls_issue_scheduler: directed scenarios plus a randomized run against a queue-based model
module tb_ls_issue_scheduler;
  logic clk = 1'b0, rst, flush, dispatch_valid, dispatch_base_ready, dispatch_data_ready;
  logic [4:0] dispatch_op;
  logic [2:0] dispatch_rob, dispatch_base_tag, dispatch_data_tag, cdb_rob;
  logic [31:0] dispatch_base_val, dispatch_imm, dispatch_data_val, cdb_value;
  logic cdb_valid, au_ready, full, issue_valid;
  logic [31:0] value1, value2, ls_value;
  logic [4:0] op_output;
  logic [2:0] rob_number_output;
  int checks = 0, errors = 0;

  typedef struct {
    logic [4:0] op; logic [2:0] rob; logic [31:0] bv; logic [2:0] bt; logic br;
    logic [31:0] imm; logic [31:0] dv; logic [2:0] dt; logic dr;
  } ent_t;

  ls_issue_scheduler #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dispatch_valid(dispatch_valid),
    .dispatch_op(dispatch_op), .dispatch_rob(dispatch_rob),
    .dispatch_base_val(dispatch_base_val), .dispatch_base_tag(dispatch_base_tag),
    .dispatch_base_ready(dispatch_base_ready), .dispatch_imm(dispatch_imm),
    .dispatch_data_val(dispatch_data_val), .dispatch_data_tag(dispatch_data_tag),
    .dispatch_data_ready(dispatch_data_ready), .full(full), .cdb_valid(cdb_valid),
    .cdb_rob(cdb_rob), .cdb_value(cdb_value), .au_ready(au_ready),
    .issue_valid(issue_valid), .value1(value1), .value2(value2), .op_output(op_output),
    .rob_number_output(rob_number_output), .ls_value(ls_value)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic au);
    rst = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0; au_ready = au;
    dispatch_op = '0; dispatch_rob = '0; dispatch_base_val = '0; dispatch_base_tag = '0;
    dispatch_base_ready = 1'b0; dispatch_imm = '0; dispatch_data_val = '0;
    dispatch_data_tag = '0; dispatch_data_ready = 1'b0; cdb_rob = '0; cdb_value = '0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [2:0] rob, input logic [31:0] bv,
                      input logic [2:0] bt, input logic br, input logic [31:0] imm,
                      input logic [31:0] dv, input logic [2:0] dt, input logic dr);
    dispatch_valid = 1'b1; dispatch_op = op; dispatch_rob = rob; dispatch_base_val = bv;
    dispatch_base_tag = bt; dispatch_base_ready = br; dispatch_imm = imm;
    dispatch_data_val = dv; dispatch_data_tag = dt; dispatch_data_ready = dr;
  endtask

  task automatic test_reset();
    idle(1'b0); rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %b want 0", issue_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (value1 !== 32'h0 || value2 !== 32'h0 || ls_value !== 32'h0) begin errors++; $display("FAIL reset_values: got %h %h %h want 0", value1, value2, ls_value); end
    checks++; if (op_output !== 5'h0 || rob_number_output !== 3'h0) begin errors++; $display("FAIL reset_op_rob: got %h %h want 0", op_output, rob_number_output); end
  endtask

  task automatic test_ready_load();
    idle(1'b1); disp(5'h03, 3'd2, 32'h1000, 3'd0, 1'b1, 32'h10, 32'h0, 3'd0, 1'b1);
    cyc();
    idle(1'b1);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL load_same_edge: got %b want 0", issue_valid); end
    cyc();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL load_issue: got %b want 1", issue_valid); end
    checks++; if (value1 !== 32'h1000 || value2 !== 32'h10) begin errors++; $display("FAIL load_values: got %h %h want 1000 10", value1, value2); end
    checks++; if (rob_number_output !== 3'd2 || op_output !== 5'h03) begin errors++; $display("FAIL load_rob_op: got %h %h want 2 03", rob_number_output, op_output); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL load_full: got %b want 0", full); end
    cyc();
    checks++; if (issue_valid !== 1'b0 || value1 !== 32'h1000) begin errors++; $display("FAIL load_pulse_hold: got %b %h want 0 1000", issue_valid, value1); end
  endtask

  task automatic test_cdb_wakeup();
    idle(1'b1); disp(5'h07, 3'd3, 32'h0, 3'd4, 1'b0, 32'h20, 32'hDEAD, 3'd0, 1'b1);
    cyc();
    idle(1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_early_issue%0d: got %b want 0", i, issue_valid); end
    end
    cdb_valid = 1'b1; cdb_rob = 3'd4; cdb_value = 32'h2000;
    cyc();
    idle(1'b1);
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_same_edge: got %b want 0", issue_valid); end
    cyc();
    checks++; if (issue_valid !== 1'b1 || value1 !== 32'h2000) begin errors++; $display("FAIL wake_issue: got %b %h want 1 2000", issue_valid, value1); end
    checks++; if (ls_value !== 32'hDEAD || value2 !== 32'h20) begin errors++; $display("FAIL wake_data: got %h %h want dead 20", ls_value, value2); end
  endtask

  task automatic test_full();
    idle(1'b0);
    for (int i = 0; i < 4; i++) begin
      disp(5'h01, 3'(i), 32'h100 + 32'(i), 3'd0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b1);
      cyc();
      checks++; if (full !== (i == 3)) begin errors++; $display("FAIL full_fill%0d: got %b want %b", i, full, i == 3); end
    end
    disp(5'h01, 3'd7, 32'h777, 3'd0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b1);
    cyc();
    checks++; if (full !== 1'b1 || issue_valid !== 1'b0) begin errors++; $display("FAIL full_drop: got %b %b want 1 0", full, issue_valid); end
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (issue_valid !== 1'b1 || rob_number_output !== 3'(i) || value1 !== 32'h100 + 32'(i)) begin errors++; $display("FAIL full_drain%0d: got %b %0d %h want 1 %0d %h", i, issue_valid, rob_number_output, value1, i, 32'h100 + i); end
      if (i == 0) begin checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_deassert: got %b want 0", full); end end
    end
    cyc();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_dropped_issued: got %b want 0", issue_valid); end
  endtask

  task automatic test_inorder();
    idle(1'b1); disp(5'h02, 3'd5, 32'h0, 3'd1, 1'b0, 32'h4, 32'h0, 3'd0, 1'b1);
    cyc();
    disp(5'h02, 3'd6, 32'h600, 3'd0, 1'b1, 32'h8, 32'h0, 3'd0, 1'b1);
    cyc();
    idle(1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_bypass%0d: got %b want 0", i, issue_valid); end
    end
    cdb_valid = 1'b1; cdb_rob = 3'd1; cdb_value = 32'h111;
    cyc();
    idle(1'b1);
    cyc();
    checks++; if (issue_valid !== 1'b1 || rob_number_output !== 3'd5 || value1 !== 32'h111) begin errors++; $display("FAIL order_head: got %b %0d %h want 1 5 111", issue_valid, rob_number_output, value1); end
    cyc();
    checks++; if (issue_valid !== 1'b1 || rob_number_output !== 3'd6 || value1 !== 32'h600) begin errors++; $display("FAIL order_young: got %b %0d %h want 1 6 600", issue_valid, rob_number_output, value1); end
    cyc();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL order_tail: got %b want 0", issue_valid); end
  endtask

  task automatic test_bypass();
    idle(1'b1); disp(5'h04, 3'd0, 32'h0, 3'd6, 1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
    cdb_valid = 1'b1; cdb_rob = 3'd6; cdb_value = 32'hABCD;
    cyc();
    idle(1'b1);
    cyc();
    checks++; if (issue_valid !== 1'b1 || value1 !== 32'hABCD) begin errors++; $display("FAIL bypass_issue: got %b %h want 1 abcd", issue_valid, value1); end
  endtask

  task automatic test_flush();
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      disp(5'h05, 3'(i + 1), 32'h50, 3'd0, 1'b1, 32'h0, 32'h0, 3'd0, 1'b1);
      cyc();
    end
    idle(1'b1); flush = 1'b1;
    cyc();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL flush_outputs: got %b %b want 0 0", issue_valid, full); end
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_issue%0d: got %b want 0", i, issue_valid); end
    end
    disp(5'h06, 3'd4, 32'h44, 3'd0, 1'b1, 32'h1, 32'h0, 3'd0, 1'b1);
    cyc();
    idle(1'b1);
    cyc();
    checks++; if (issue_valid !== 1'b1 || rob_number_output !== 3'd4 || value1 !== 32'h44) begin errors++; $display("FAIL flush_recover: got %b %0d %h want 1 4 44", issue_valid, rob_number_output, value1); end
  endtask

  task automatic test_rst_mid();
    idle(1'b1); disp(5'h09, 3'd1, 32'h91, 3'd0, 1'b1, 32'h9, 32'h99, 3'd0, 1'b1);
    cyc();
    disp(5'h0A, 3'd2, 32'hA1, 3'd0, 1'b1, 32'hA, 32'hAA, 3'd0, 1'b1);
    cyc();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_issue: got %b want 1", issue_valid); end
    idle(1'b1); rst = 1'b1;
    cyc();
    checks++; if (issue_valid !== 1'b0 || full !== 1'b0 || value1 !== 32'h0 || value2 !== 32'h0 || ls_value !== 32'h0 || op_output !== 5'h0 || rob_number_output !== 3'h0) begin errors++; $display("FAIL rst_mid_outputs: got %b %b %h %h %h %h %h want all 0", issue_valid, full, value1, value2, ls_value, op_output, rob_number_output); end
    rst = 1'b0;
    cyc();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got %b want 0", issue_valid); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e, h;
    logic e_iv;
    logic [31:0] e_v1, e_v2, e_ls;
    logic [4:0] e_op;
    logic [2:0] e_rob;
    logic was_full, iss;
    idle(1'b0); rst = 1'b1;
    cyc();
    rst = 1'b0;
    e_iv = 0; e_v1 = 0; e_v2 = 0; e_ls = 0; e_op = 0; e_rob = 0;
    for (int c = 0; c < 400; c++) begin
      dispatch_valid = 1'($urandom_range(0, 1)); dispatch_op = 5'($urandom);
      dispatch_rob = 3'($urandom); dispatch_base_val = $urandom; dispatch_base_tag = 3'($urandom);
      dispatch_base_ready = 1'($urandom_range(0, 1)); dispatch_imm = $urandom;
      dispatch_data_val = $urandom; dispatch_data_tag = 3'($urandom);
      dispatch_data_ready = 1'($urandom_range(0, 1));
      cdb_valid = ($urandom_range(0, 9) < 4); cdb_rob = 3'($urandom); cdb_value = $urandom;
      au_ready = ($urandom_range(0, 9) < 7); flush = ($urandom_range(0, 99) < 3);
      was_full = (q.size() == 4);
      if (flush) begin
        q.delete();
        e_iv = 0;
      end else begin
        iss = q.size() != 0 && q[0].br && q[0].dr && au_ready;
        for (int k = 0; k < q.size(); k++) begin
          e = q[k];
          if (cdb_valid && !e.br && e.bt == cdb_rob) begin e.bv = cdb_value; e.br = 1; end
          if (cdb_valid && !e.dr && e.dt == cdb_rob) begin e.dv = cdb_value; e.dr = 1; end
          q[k] = e;
        end
        e_iv = iss;
        if (iss) begin
          h = q.pop_front();
          e_v1 = h.bv; e_v2 = h.imm; e_ls = h.dv; e_op = h.op; e_rob = h.rob;
        end
        if (dispatch_valid && !was_full) begin
          e.op = dispatch_op; e.rob = dispatch_rob; e.imm = dispatch_imm;
          e.bt = dispatch_base_tag; e.dt = dispatch_data_tag;
          e.br = dispatch_base_ready || (cdb_valid && dispatch_base_tag == cdb_rob);
          e.bv = dispatch_base_ready ? dispatch_base_val : (e.br ? cdb_value : dispatch_base_val);
          e.dr = dispatch_data_ready || (cdb_valid && dispatch_data_tag == cdb_rob);
          e.dv = dispatch_data_ready ? dispatch_data_val : (e.dr ? cdb_value : dispatch_data_val);
          q.push_back(e);
        end
      end
      cyc();
      checks++; if (issue_valid !== e_iv) begin errors++; $display("FAIL rand_issue_valid c%0d: got %b want %b", c, issue_valid, e_iv); end
      checks++; if (full !== (q.size() == 4)) begin errors++; $display("FAIL rand_full c%0d: got %b want %b", c, full, q.size() == 4); end
      checks++; if (value1 !== e_v1 || value2 !== e_v2 || ls_value !== e_ls || op_output !== e_op || rob_number_output !== e_rob) begin errors++; $display("FAIL rand_outputs c%0d: got %h %h %h %h %h want %h %h %h %h %h", c, value1, value2, ls_value, op_output, rob_number_output, e_v1, e_v2, e_ls, e_op, e_rob); end
    end
    idle(1'b0);
  endtask

  initial begin
    idle(1'b0); rst = 1'b1;
    test_reset();
    test_ready_load();
    test_cdb_wakeup();
    test_full();
    test_inorder();
    test_bypass();
    test_flush();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
